// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ producers.
// Grants one requester per burst of up to MAX_BURST beats and tags every beat with its source index.
module async_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           fifo_wclk,
  input  logic                           fifo_wrst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wen,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
  output logic                           grant_vld,
  output logic [ID_WIDTH-1:0]            grant_id
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic [ID_WIDTH-1:0]   next_ptr;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Mux of the granted requester's valid/payload
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Zero-latency pass-through from the granted requester to the FIFO port
  always_comb begin
    req_ready  = '0;
    xfer       = 1'b0;
    fifo_wen   = 1'b0;
    fifo_wdata = '0;
    if (state_q == GRANT) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_id_q == ID_WIDTH'(i)) && !fifo_full;
      end
      xfer       = sel_valid && !fifo_full;
      fifo_wen   = xfer;
      fifo_wdata = {grant_id_q, sel_data};
    end
  end

  assign next_ptr  = (grant_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                            : grant_id_q + ID_WIDTH'(1);
  assign grant_vld = (state_q == GRANT);
  assign grant_id  = grant_id_q;

  // Next-state: grant on any valid, release on burst end or requester dropping valid
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d    = GRANT;
          grant_id_d = arb_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!sel_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fifo_wclk or negedge fifo_wrst_n) begin
    if (!fifo_wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Scoreboard bench for async_fifo_wr_arbiter: directed bursts, expected FIFO writes and
// grant order queued at stimulus time, popped by a negedge monitor.
module tb_async_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned FW = IW + DW;

  logic            fifo_wclk = 1'b0;
  logic            fifo_wrst_n;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wen;
  logic [FW-1:0]   fifo_wdata;
  logic            grant_vld;
  logic [IW-1:0]   grant_id;

  int unsigned src_len[NR] = '{default: 0};
  int unsigned src_idx[NR] = '{default: 0};
  logic [FW-1:0] exp_q[$];
  logic [IW-1:0] exp_gnt[$];
  int errors = 0;
  int checks = 0;
  logic gv_prev = 1'b0;

  async_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .fifo_wclk  (fifo_wclk),
    .fifo_wrst_n(fifo_wrst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  always #5 fifo_wclk = ~fifo_wclk;

  // Requester models: beat k of requester r carries r*16+k
  always begin
    @(posedge fifo_wclk);
    #2;
    for (int i = 0; i < int'(NR); i++) begin
      req_valid[i]         = (src_idx[i] < src_len[i]);
      req_data[i*DW +: DW] = 8'(i*16 + int'(src_idx[i]));
    end
  end

  // Monitor: handshakes advance requesters, writes and new grants pop the scoreboard
  always @(negedge fifo_wclk) begin
    logic [FW-1:0] ew;
    logic [IW-1:0] eg;
    if (fifo_wrst_n) begin
      for (int i = 0; i < int'(NR); i++)
        if (req_valid[i] && req_ready[i]) src_idx[i]++;
    end
    if (fifo_wen) begin
      checks++;
      if (fifo_full) begin
        errors++;
        $display("FAIL write_while_full got wen=1 full=1 required no write");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%h required=none", fifo_wdata);
      end else begin
        ew = exp_q.pop_front();
        if (fifo_wdata !== ew) begin
          errors++;
          $display("FAIL fifo_wdata got=%h required=%h", fifo_wdata, ew);
        end
      end
    end
    if (grant_vld && !gv_prev) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant got=%0d required=none", grant_id);
      end else begin
        eg = exp_gnt.pop_front();
        if (grant_id !== eg) begin
          errors++;
          $display("FAIL grant_order got=%0d required=%0d", grant_id, eg);
        end
      end
    end
    gv_prev = grant_vld;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic expect_beats(input int r, input int first, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({IW'(r), DW'(r*16 + first + k)});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge fifo_wclk);
      n++;
    end while (!(exp_q.size() == 0 && exp_gnt.size() == 0 && !grant_vld) && n < budget);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got writes_left=%0d grants_left=%0d required=0",
               exp_q.size(), exp_gnt.size());
    end
  endtask

  task automatic wait_grant(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge fifo_wclk);
      n++;
    end while (!grant_vld && n < budget);
    checks++;
    if (!grant_vld) begin
      errors++;
      $display("FAIL grant_timeout got grant_vld=0 required=1");
    end
  endtask

  initial begin
    int base[NR];
    fifo_wrst_n = 1'b0;
    fifo_full   = 1'b0;
    repeat (3) @(posedge fifo_wclk);
    #1;
    chk("reset_grant_vld", 32'(grant_vld), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_fifo_wen", 32'(fifo_wen), 32'd0);
    chk("reset_fifo_wdata", 32'(fifo_wdata), 32'd0);
    fifo_wrst_n = 1'b1;

    // Reset mid-GRANT while stalled on full; pending req 2 beat must survive
    @(posedge fifo_wclk); #1;
    fifo_full  = 1'b1;
    src_len[2] = 1;
    exp_gnt.push_back(IW'(2));
    repeat (3) @(posedge fifo_wclk);
    #3;
    chk("stall_grant_vld", 32'(grant_vld), 32'd1);
    chk("stall_grant_id", 32'(grant_id), 32'd2);
    chk("stall_fifo_wen", 32'(fifo_wen), 32'd0);
    fifo_wrst_n = 1'b0;
    #1;
    chk("midrst_grant_vld", 32'(grant_vld), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_fifo_wen", 32'(fifo_wen), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    fifo_full  = 1'b0;
    src_len[1] = 1;
    src_len[3] = 1;
    exp_gnt.push_back(IW'(1)); exp_gnt.push_back(IW'(2)); exp_gnt.push_back(IW'(3));
    expect_beats(1, 0, 1); expect_beats(2, 0, 1); expect_beats(3, 0, 1);
    #20;
    fifo_wrst_n = 1'b1;
    wait_idle(60);

    // Round robin: all four valid, full bursts of MB beats, rr_ptr starts at 0
    @(posedge fifo_wclk); #1;
    base = '{0, 1, 1, 1};
    for (int r = 0; r < int'(NR); r++) src_len[r] += 8;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < int'(NR); r++) begin
        exp_gnt.push_back(IW'(r));
        expect_beats(r, base[r] + p*4, 4);
      end
    wait_idle(200);

    // Backpressure: full for 5 cycles after the first beat of a req 0 burst
    @(posedge fifo_wclk); #1;
    src_len[0] += 4;
    exp_gnt.push_back(IW'(0));
    expect_beats(0, 8, 4);
    wait_grant(10);
    @(posedge fifo_wclk); #1;
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge fifo_wclk);
      chk("bp_fifo_wen", 32'(fifo_wen), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_grant_held", 32'({grant_vld, grant_id}), 32'({1'b1, 2'd0}));
    end
    @(posedge fifo_wclk); #1;
    fifo_full = 1'b0;
    wait_idle(40);

    // Early release of req 2 after 2 beats, then search resumes at 3 and wraps to 0
    @(posedge fifo_wclk); #1;
    src_len[2] += 2;
    exp_gnt.push_back(IW'(2));
    expect_beats(2, 9, 2);
    wait_grant(10);
    @(posedge fifo_wclk); #1;
    src_len[3] += 1;
    src_len[0] += 1;
    exp_gnt.push_back(IW'(3)); exp_gnt.push_back(IW'(0));
    expect_beats(3, 9, 1); expect_beats(0, 12, 1);
    wait_idle(40);

    // rr_ptr now 1: reqs 0,1,2 valid -> 1, 2, 0
    @(posedge fifo_wclk); #1;
    src_len[0] += 1; src_len[1] += 1; src_len[2] += 1;
    exp_gnt.push_back(IW'(1)); exp_gnt.push_back(IW'(2)); exp_gnt.push_back(IW'(0));
    expect_beats(1, 9, 1); expect_beats(2, 11, 1); expect_beats(0, 13, 1);
    wait_idle(40);

    for (int r = 0; r < int'(NR); r++) chk("beats_accepted", src_idx[r], src_len[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
